i2c_seq_ctrl: RTL and testbench
===============================

# i2c_seq_ctrl

Transaction sequencer sitting between two on-chip requesters and a byte-level I2C master engine. It arbitrates requests round-robin, then expands each granted request into the engine command sequence for a register access. The access is a register write of 1–2 bytes, or a register read of 1–2 bytes using a repeated start. On the slave side, this matches the command/register protocol: chip-ID read, and 16-bit value read high then low. Results and ACK errors return to the requester with a one-cycle done pulse.

## Interface
- TIMEOUT_CYCLES, 16'd50000: max cycles waiting on `eng_done` per engine command (used only with the timeout feature).
- SLAVE_DEFAULT, 7'h3C: device address used when a requester drives 7'h00.

Clock is `clk`; reset is `reset`, synchronous, active-low.
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-low.
- req  in  2  per-requester request level; held until matching done.
- req_rw  in  2  per-requester, 1=read, 0=write.
- req_len2  in  2  per-requester, 1=two data bytes, 0=one.
- req_dev  in  14  {dev1,dev0} 7-bit device addresses.
- req_reg  in  16  {reg1,reg0} register/command bytes.
- req_wdata  in  32  {wd1,wd0}; 16 bits each, high byte sent first; low byte only when len2=0.
- gnt  out  2  one-hot grant, held for the whole transaction.
- done  out  2  one-cycle pulse to the granted requester at completion.
- rdata  out  16  read result, valid with done; 1-byte reads return {8'h00,byte}.
- err  out  1  valid with done; 1 = NACK or timeout.
- eng_valid  out  1  command valid to engine.
- eng_ready  in  1  engine accepts command when valid&ready.
- eng_op  out  3  0 IDLE, 1 START, 2 WRITE, 3 READ, 4 STOP.
- eng_data  out  8  byte for START (addr<<1|rw) / WRITE.
- eng_nack  out  1  with READ: master NACKs this byte (last byte).
- eng_done  in  1  one-cycle pulse, current command finished on bus.
- eng_rdata  in  8  valid with eng_done after READ.
- eng_ack_err  in  1  valid with eng_done after START/WRITE; 1 = slave NACK.

## Operation
- Reset values: gnt=0, done=0, rdata=0, err=0, eng_valid=0, eng_op=IDLE, eng_data=0, eng_nack=0; state IDLE; round-robin pointer=requester 0.
- States: IDLE, SADDR_W, REG, WD_H, WD_L, SADDR_R, RD_H, RD_L, STOP, FIN.
- IDLE: if any req, grant per round-robin (priority to requester not served last), latch request fields, go SADDR_W.
- SADDR_W: START with {dev,0}.
- REG: WRITE with reg byte.
- After REG, write path: WD_H is issued only if len2=1, then WD_L (WRITE wdata low), then STOP.
- After REG, read path: SADDR_R (START {dev,1}, i.e. a repeated start), then RD_H is issued only if len2=1 (eng_nack=0), then RD_L (eng_nack=1), then STOP.
- Each command state: assert eng_valid with op/data until eng_ready; then deassert and wait for eng_done; then advance.
- eng_ack_err=1 on any START/WRITE sets err and jumps directly to STOP; remaining bytes are skipped.
- RD_H captures rdata[15:8]; RD_L captures rdata[7:0].
- STOP: issue STOP, wait eng_done, go FIN.
- FIN: pulse done[granted], clear gnt, toggle pointer, return IDLE.
- A requester dropping req mid-transaction does not abort it; done still pulses.
- Both req asserted in the same cycle: the round-robin pointer decides; back-to-back requests from both alternate strictly.

## Timing
- Grant appears 1 cycle after req is seen in IDLE.
- eng_valid rises the cycle after entering a command state; minimum 2 cycles per command plus engine latency.
- rdata/err are stable from the done cycle until the next grant.
- Next grant no earlier than 1 cycle after FIN.
- Reset asserted mid-transaction returns all outputs to reset values on the next clock. No STOP is issued; the engine is reset by the same signal.

## Configuration
- I2C_SEQ_TIMEOUT_EN defined: a 16-bit counter runs while waiting on eng_ready/eng_done. Reaching TIMEOUT_CYCLES sets err, drops eng_valid, and forces FIN directly without STOP; done pulses.
- Undefined: no counter; the block waits indefinitely.

## Structure
- Shared header I2C_SEQ.vh: eng_op codes, state encodings, ZERO8/ZERO16 constants, SLAVE_DEFAULT.
- Sub-module i2c_seq_arbiter: 2-way round-robin, inputs req/advance, output one-hot grant and pointer.

## Test plan
- Req0 write, dev 7'h3C, reg 8'h10, len2=1, wdata 16'hA55A: engine sees START 8'h78, WRITE 8'h10, WRITE 8'hA5, WRITE 8'h5A, STOP; done[0] pulses, err=0.
- Req1 read, reg 8'hD0 (chip-ID), len2=0, engine returns 8'h58: ops START 8'h78, WRITE 8'hD0, START 8'h79, READ nack=1, STOP; rdata=16'h0058.
- 16-bit read, engine returns 8'h12 then 8'h34: first READ nack=0, second nack=1; rdata=16'h1234.
- Slave NACK on address START: next op STOP; done with err=1, no REG write.
- Both req held continuously: grants alternate 0,1,0,1; no requester served twice consecutively.
- With I2C_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=100, engine never returns eng_done: done+err after 100 cycles; then reset mid-transaction clears gnt/eng_valid next clock.

Source files
------------

// File: rtl/i2c_seq_ctrl_pkg.sv
// i2c_seq_ctrl_pkg: shared engine op codes, sequencer states, request payload and constants.
package i2c_seq_ctrl_pkg;

    localparam int unsigned NREQ   = 2;
    localparam int unsigned DEV_W  = 7;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 16;

    localparam logic [DEV_W-1:0]  SLAVE_DEFAULT = 7'h3C;
    localparam logic [BYTE_W-1:0] ZERO8         = 8'h00;
    localparam logic [WORD_W-1:0] ZERO16        = 16'h0000;

    typedef enum logic [2:0] {
        OP_IDLE  = 3'd0,
        OP_START = 3'd1,
        OP_WRITE = 3'd2,
        OP_READ  = 3'd3,
        OP_STOP  = 3'd4
    } eng_op_e;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_SADDR_W = 4'd1,
        ST_REG     = 4'd2,
        ST_WD_H    = 4'd3,
        ST_WD_L    = 4'd4,
        ST_SADDR_R = 4'd5,
        ST_RD_H    = 4'd6,
        ST_RD_L    = 4'd7,
        ST_STOP    = 4'd8,
        ST_FIN     = 4'd9
    } state_e;

    // Request fields latched at grant time
    typedef struct packed {
        logic              rw;
        logic              len2;
        logic [DEV_W-1:0]  dev;
        logic [BYTE_W-1:0] regaddr;
        logic [WORD_W-1:0] wdata;
    } req_fields_t;

    // Engine command issued by each command state
    function automatic eng_op_e state_op(input state_e s);
        case (s)
            ST_SADDR_W, ST_SADDR_R:    return OP_START;
            ST_REG, ST_WD_H, ST_WD_L:  return OP_WRITE;
            ST_RD_H, ST_RD_L:          return OP_READ;
            ST_STOP:                   return OP_STOP;
            default:                   return OP_IDLE;
        endcase
    endfunction

    // States that drive an engine command
    function automatic logic is_cmd(input state_e s);
        return (s != ST_IDLE) && (s != ST_FIN);
    endfunction

endpackage

// File: rtl/i2c_seq_ctrl_if.sv
// i2c_seq_ctrl_if: command/response link between the sequencer and the byte-level I2C engine.
interface i2c_seq_ctrl_if;
    logic                           eng_valid;
    logic                           eng_ready;
    i2c_seq_ctrl_pkg::eng_op_e      eng_op;
    logic [7:0]                     eng_data;
    logic                           eng_nack;
    logic                           eng_done;
    logic [7:0]                     eng_rdata;
    logic                           eng_ack_err;

    modport master (
        output eng_valid, eng_op, eng_data, eng_nack,
        input  eng_ready, eng_done, eng_rdata, eng_ack_err
    );

    modport slave (
        input  eng_valid, eng_op, eng_data, eng_nack,
        output eng_ready, eng_done, eng_rdata, eng_ack_err
    );
endinterface

// File: rtl/i2c_seq_ctrl_arbiter.sv
// i2c_seq_ctrl_arbiter: 2-way round-robin; holds the grant for a whole transaction.
// After a transaction the priority goes to the requester that was not just served.
module i2c_seq_ctrl_arbiter
    import i2c_seq_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            load,
    input  logic            advance,
    output logic [NREQ-1:0] pick_c,
    output logic [NREQ-1:0] gnt,
    output logic            ptr
);

    // Candidate winner: the pointer names the requester with priority
    always_comb begin
        pick_c = 2'b00;
        if (ptr) begin
            if (req[1])      pick_c = 2'b10;
            else if (req[0]) pick_c = 2'b01;
        end else begin
            if (req[0])      pick_c = 2'b01;
            else if (req[1]) pick_c = 2'b10;
        end
    end

    // Grant register and round-robin pointer
    always_ff @(posedge clk) begin
        if (!reset) begin
            gnt <= 2'b00;
            ptr <= 1'b0;
        end else if (advance) begin
            gnt <= 2'b00;
            ptr <= gnt[0];
        end else if (load) begin
            gnt <= pick_c;
        end
    end

endmodule

// File: rtl/i2c_seq_ctrl.sv
// i2c_seq_ctrl: arbitrates two requesters and expands each grant into I2C engine commands
// for a 1-2 byte register write or a repeated-start register read.
// Optional: I2C_SEQ_TIMEOUT_EN adds a per-command watchdog (TIMEOUT_CYCLES) that ends
// the transaction with err=1 and no STOP.
module i2c_seq_ctrl
    import i2c_seq_ctrl_pkg::*;
`ifdef I2C_SEQ_TIMEOUT_EN
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
)
`endif
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         req_rw,
    input  logic [NREQ-1:0]         req_len2,
    input  logic [NREQ*DEV_W-1:0]   req_dev,
    input  logic [NREQ*BYTE_W-1:0]  req_reg,
    input  logic [NREQ*WORD_W-1:0]  req_wdata,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic [WORD_W-1:0]       rdata,
    output logic                    err,
    i2c_seq_ctrl_if.master          eng
);

    state_e            state, state_nxt;
    logic              phase, phase_nxt;      // 0: offering command, 1: waiting for eng_done
    req_fields_t       cur;
    req_fields_t       fld [NREQ];
    logic [NREQ-1:0]   pick_c;
    logic              ptr;
    logic              load_c, advance_c, accept_c, timeout_c, wr_like_c;
    logic [BYTE_W-1:0] cmd_data_c;

    logic              valid_nxt, nack_nxt, err_nxt;
    eng_op_e           op_nxt;
    logic [BYTE_W-1:0] data_nxt;
    logic [NREQ-1:0]   done_nxt;
    logic [WORD_W-1:0] rdata_nxt;

    assign load_c    = (state == ST_IDLE) && (|req);
    assign advance_c = (state == ST_FIN);
    assign accept_c  = eng.eng_valid && eng.eng_ready;
    assign wr_like_c = (state_op(state) == OP_START) || (state_op(state) == OP_WRITE);

    i2c_seq_ctrl_arbiter u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .load    (load_c),
        .advance (advance_c),
        .pick_c  (pick_c),
        .gnt     (gnt),
        .ptr     (ptr)
    );

    // Unpack per-requester fields; address 0 selects the default slave
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            fld[i].rw      = req_rw[i];
            fld[i].len2    = req_len2[i];
            fld[i].dev     = (req_dev[i*DEV_W +: DEV_W] == 7'h00) ? SLAVE_DEFAULT
                                                                  : req_dev[i*DEV_W +: DEV_W];
            fld[i].regaddr = req_reg[i*BYTE_W +: BYTE_W];
            fld[i].wdata   = req_wdata[i*WORD_W +: WORD_W];
        end
    end

    // Latch the winner's request so a dropped req cannot disturb the transaction
    always_ff @(posedge clk) begin
        if (!reset)      cur <= '0;
        else if (load_c) cur <= fld[pick_c[1]];
    end

`ifdef I2C_SEQ_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    // Per-command watchdog, restarted whenever the state changes
    always_ff @(posedge clk) begin
        if (!reset)                                   tmo_cnt <= 16'd0;
        else if (!is_cmd(state) || state_nxt != state) tmo_cnt <= 16'd0;
        else                                          tmo_cnt <= tmo_cnt + 16'd1;
    end

    assign timeout_c = is_cmd(state) && (tmo_cnt == TIMEOUT_CYCLES - 16'd1);
`else
    assign timeout_c = 1'b0;
`endif

    // Byte carried by the current command state
    always_comb begin
        cmd_data_c = ZERO8;
        case (state)
            ST_SADDR_W: cmd_data_c = {cur.dev, 1'b0};
            ST_SADDR_R: cmd_data_c = {cur.dev, 1'b1};
            ST_REG:     cmd_data_c = cur.regaddr;
            ST_WD_H:    cmd_data_c = cur.wdata[15:8];
            ST_WD_L:    cmd_data_c = cur.wdata[7:0];
            default:    cmd_data_c = ZERO8;
        endcase
    end

    // State register plus registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ST_IDLE;
            phase         <= 1'b0;
            eng.eng_valid <= 1'b0;
            eng.eng_op    <= OP_IDLE;
            eng.eng_data  <= ZERO8;
            eng.eng_nack  <= 1'b0;
            done          <= 2'b00;
            rdata         <= ZERO16;
            err           <= 1'b0;
        end else begin
            state         <= state_nxt;
            phase         <= phase_nxt;
            eng.eng_valid <= valid_nxt;
            eng.eng_op    <= op_nxt;
            eng.eng_data  <= data_nxt;
            eng.eng_nack  <= nack_nxt;
            done          <= done_nxt;
            rdata         <= rdata_nxt;
            err           <= err_nxt;
        end
    end

    // Next state: command sequencing, NACK abort to STOP, watchdog to FIN
    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    state_nxt = ST_SADDR_W;
                    phase_nxt = 1'b0;
                end
            end
            ST_FIN: begin
                state_nxt = ST_IDLE;
                phase_nxt = 1'b0;
            end
            default: begin
                if (timeout_c) begin
                    state_nxt = ST_FIN;
                    phase_nxt = 1'b0;
                end else if (!phase) begin
                    if (accept_c) phase_nxt = 1'b1;
                end else if (eng.eng_done) begin
                    phase_nxt = 1'b0;
                    if (wr_like_c && eng.eng_ack_err) begin
                        state_nxt = ST_STOP;
                    end else begin
                        case (state)
                            ST_SADDR_W: state_nxt = ST_REG;
                            ST_REG:     state_nxt = cur.rw ? ST_SADDR_R
                                                           : (cur.len2 ? ST_WD_H : ST_WD_L);
                            ST_WD_H:    state_nxt = ST_WD_L;
                            ST_WD_L:    state_nxt = ST_STOP;
                            ST_SADDR_R: state_nxt = cur.len2 ? ST_RD_H : ST_RD_L;
                            ST_RD_H:    state_nxt = ST_RD_L;
                            ST_RD_L:    state_nxt = ST_STOP;
                            ST_STOP:    state_nxt = ST_FIN;
                            default:    state_nxt = ST_IDLE;
                        endcase
                    end
                end
            end
        endcase
    end

    // Output next-values: command offer, read capture, error and done pulse (done lands in FIN)
    always_comb begin
        valid_nxt = 1'b0;
        op_nxt    = OP_IDLE;
        data_nxt  = ZERO8;
        nack_nxt  = 1'b0;
        done_nxt  = 2'b00;
        err_nxt   = err;
        rdata_nxt = rdata;
        if (load_c) begin
            err_nxt   = 1'b0;
            rdata_nxt = ZERO16;
        end
        if (is_cmd(state)) begin
            if (timeout_c) begin
                err_nxt  = 1'b1;
                done_nxt = gnt;
            end else if (!phase) begin
                if (!accept_c) begin
                    valid_nxt = 1'b1;
                    op_nxt    = state_op(state);
                    data_nxt  = cmd_data_c;
                    nack_nxt  = (state == ST_RD_L);
                end
            end else if (eng.eng_done) begin
                case (state)
                    ST_RD_H: rdata_nxt[15:8] = eng.eng_rdata;
                    ST_RD_L: rdata_nxt[7:0]  = eng.eng_rdata;
                    ST_STOP: done_nxt        = gnt;
                    default: ;
                endcase
                if (wr_like_c && eng.eng_ack_err) err_nxt = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2c_seq_ctrl.sv
// tb_i2c_seq_ctrl: table-driven and randomized checks of i2c_seq_ctrl against a
// transaction-level model; a scripted engine responder logs every accepted command.
module tb_i2c_seq_ctrl;
    import i2c_seq_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req = 2'b00, req_rw = 2'b00, req_len2 = 2'b00;
    logic [13:0] req_dev = '0;
    logic [15:0] req_reg = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  gnt, done;
    logic [15:0] rdata;
    logic        err;

    i2c_seq_ctrl_if eng();

`ifdef I2C_SEQ_TIMEOUT_EN
    i2c_seq_ctrl #(.TIMEOUT_CYCLES(16'd100)) dut (
        .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_len2(req_len2),
        .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
        .gnt(gnt), .done(done), .rdata(rdata), .err(err), .eng(eng.master));
`else
    i2c_seq_ctrl dut (
        .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_len2(req_len2),
        .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
        .gnt(gnt), .done(done), .rdata(rdata), .err(err), .eng(eng.master));
`endif

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] data;
        logic       nack;
    } cmd_t;

    typedef struct {
        int         idx;
        bit         rw;
        bit         len2;
        logic [6:0] dev;
        logic [7:0] rg;
        logic [15:0] wd;
        int         nack_at;
        logic [7:0] b0;
        logic [7:0] b1;
    } vec_t;

    int   n_chk = 0, n_fail = 0;
    int   last = 1;                  // requester served last; after reset requester 0 has priority
    cmd_t log_q[$], exp_q[$];
    logic [7:0] rd_q[$];
    bit   exp_err;
    logic [15:0] exp_rdata;

    // engine responder state
    int   cmd_idx = 0, nack_at = -1, eng_rdly = 0, eng_cd = 0;
    bit   eng_busy = 0, hang = 0, pend_nack = 0;
    logic [7:0] pend_rd = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Engine: random accept delay, random done latency, NACK on a chosen command index
    initial begin
        eng.eng_ready = 0; eng.eng_done = 0; eng.eng_rdata = 0; eng.eng_ack_err = 0;
        forever begin
            @(negedge clk);
            eng.eng_ready = 0; eng.eng_done = 0; eng.eng_ack_err = 0; eng.eng_rdata = 0;
            if (!reset) begin
                eng_busy = 0; eng_rdly = 0;
            end else if (eng_busy) begin
                if (!hang) begin
                    if (eng_cd == 0) begin
                        eng.eng_done = 1; eng.eng_ack_err = pend_nack; eng.eng_rdata = pend_rd;
                        eng_busy = 0;
                    end else eng_cd--;
                end
            end else if (eng.eng_valid) begin
                if (eng_rdly == 0) begin
                    eng.eng_ready = 1;
                    log_q.push_back(cmd_t'{op: 3'(eng.eng_op), data: eng.eng_data, nack: eng.eng_nack});
                    pend_nack = ((eng.eng_op == OP_START) || (eng.eng_op == OP_WRITE)) && (cmd_idx == nack_at);
                    pend_rd   = ((eng.eng_op == OP_READ) && (rd_q.size() > 0)) ? rd_q.pop_front() : 8'h00;
                    cmd_idx++;
                    eng_busy = 1;
                    eng_cd    = int'($urandom_range(0, 2));
                    eng_rdly  = int'($urandom_range(0, 2));
                end else eng_rdly--;
            end
        end
    end

    // Model: append a command; report whether the engine NACKs it
    function automatic bit push_cmd(input eng_op_e op, input logic [7:0] d, input bit nk, input int na);
        bit hit;
        hit = (exp_q.size() == na) && ((op == OP_START) || (op == OP_WRITE));
        exp_q.push_back(cmd_t'{op: 3'(op), data: d, nack: nk});
        return hit;
    endfunction

    // Model: expected command list, err and rdata for one register access
    function automatic void build_exp(input vec_t v);
        logic [6:0] d;
        logic [7:0] wb[$];
        bit ab;
        exp_q.delete(); exp_rdata = 16'h0000;
        d  = (v.dev == 7'h00) ? 7'h3C : v.dev;
        ab = push_cmd(OP_START, {d, 1'b0}, 0, v.nack_at);
        if (!ab) ab = push_cmd(OP_WRITE, v.rg, 0, v.nack_at);
        if (!ab && !v.rw) begin
            if (v.len2) wb.push_back(v.wd[15:8]);
            wb.push_back(v.wd[7:0]);
            foreach (wb[k]) if (!ab) ab = push_cmd(OP_WRITE, wb[k], 0, v.nack_at);
        end else if (!ab) begin
            ab = push_cmd(OP_START, {d, 1'b1}, 0, v.nack_at);
            if (!ab) begin
                if (v.len2) begin
                    void'(push_cmd(OP_READ, 8'h00, 0, v.nack_at));
                    exp_rdata = {v.b0, v.b1};
                end else exp_rdata = {8'h00, v.b0};
                void'(push_cmd(OP_READ, 8'h00, 1, v.nack_at));
            end
        end
        void'(push_cmd(OP_STOP, 8'h00, 0, v.nack_at));
        exp_err = ab;
    endfunction

    task automatic run_txn(input vec_t v, input string nm);
        int n;
        build_exp(v);
        log_q.delete(); rd_q.delete(); rd_q.push_back(v.b0); rd_q.push_back(v.b1);
        cmd_idx = 0; nack_at = v.nack_at;
        req_rw[v.idx] = v.rw; req_len2[v.idx] = v.len2;
        req_dev[v.idx*7 +: 7] = v.dev; req_reg[v.idx*8 +: 8] = v.rg; req_wdata[v.idx*16 +: 16] = v.wd;
        req[v.idx] = 1'b1;
        @(negedge clk);
        chk({nm, ".gnt"}, gnt, 32'(1 << v.idx));
        n = 0;
        while (done == 2'b00 && n < 2000) begin @(negedge clk); n++; end
        if (n >= 2000) begin
            n_chk++; n_fail++;
            $display("FAIL %s.done_timeout: got no done expected done within 2000 cycles", nm);
        end
        chk({nm, ".done"}, done, 32'(1 << v.idx));
        chk({nm, ".err"}, err, exp_err);
        chk({nm, ".rdata"}, rdata, exp_rdata);
        req[v.idx] = 1'b0;
        last = v.idx;
        @(negedge clk);
        chk({nm, ".done_pulse"}, {gnt, done}, 4'b0000);
        chk({nm, ".rdata_hold"}, rdata, exp_rdata);
        chk({nm, ".ncmd"}, log_q.size(), exp_q.size());
        foreach (exp_q[k]) if (k < log_q.size()) chk($sformatf("%s.cmd%0d", nm, k), log_q[k], exp_q[k]);
    endtask

    vec_t tbl[6];
    vec_t rv;

    initial begin
        int n, t;
        tbl[0] = '{0, 0, 1, 7'h3C, 8'h10, 16'hA55A, -1, 8'h00, 8'h00};
        tbl[1] = '{1, 1, 0, 7'h00, 8'hD0, 16'h0000, -1, 8'h58, 8'h00};
        tbl[2] = '{0, 1, 1, 7'h3C, 8'h02, 16'h0000, -1, 8'h12, 8'h34};
        tbl[3] = '{1, 0, 1, 7'h50, 8'h22, 16'hBEEF,  0, 8'h00, 8'h00};
        tbl[4] = '{0, 0, 0, 7'h21, 8'h05, 16'h12CD, -1, 8'h00, 8'h00};
        tbl[5] = '{1, 1, 1, 7'h2A, 8'h40, 16'h0000,  2, 8'h77, 8'h88};

        repeat (3) @(negedge clk);
        chk("rst.gnt", gnt, 0); chk("rst.done", done, 0); chk("rst.rdata", rdata, 0);
        chk("rst.err", err, 0); chk("rst.eng_valid", eng.eng_valid, 0);
        chk("rst.eng_op", eng.eng_op, 0); chk("rst.eng_data", eng.eng_data, 0);
        chk("rst.eng_nack", eng.eng_nack, 0);
        reset = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) run_txn(tbl[i], $sformatf("tbl%0d", i));

        for (int i = 0; i < 16; i++) begin
            rv.idx = int'($urandom_range(0, 1));
            rv.rw = 1'($urandom); rv.len2 = 1'($urandom);
            rv.dev = ($urandom_range(0, 3) == 0) ? 7'h00 : 7'($urandom);
            rv.rg = 8'($urandom); rv.wd = 16'($urandom);
            rv.nack_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
            rv.b0 = 8'($urandom); rv.b1 = 8'($urandom);
            run_txn(rv, $sformatf("rnd%0d", i));
        end

        // Both requesters held: grants must alternate
        nack_at = -1; log_q.delete();
        req_rw = 2'b00; req_len2 = 2'b00;
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (done == 2'b00 && n < 2000) begin @(negedge clk); n++; end
            chk($sformatf("arb%0d.done", i), done, 32'(1 << (1 - last)));
            chk($sformatf("arb%0d.gnt", i), gnt, 32'(1 << (1 - last)));
            last = 1 - last;
            if (i == 3) req = 2'b00;
            @(negedge clk);
        end
        @(negedge clk);

`ifdef I2C_SEQ_TIMEOUT_EN
        // Engine accepts but never finishes: watchdog ends the transaction without STOP
        hang = 1; log_q.delete(); cmd_idx = 0;
        req_rw[1] = 1'b0; req[1] = 1'b1;
        @(negedge clk);
        t = 0;
        while (done == 2'b00 && t < 500) begin @(negedge clk); t++; end
        chk("tmo.cycles", t, 100);
        chk("tmo.done", done, 2'b10);
        chk("tmo.err", err, 1);
        chk("tmo.ncmd", log_q.size(), 1);
        req[1] = 1'b0; last = 1;
        @(negedge clk);
`endif

        // Reset in the middle of a transaction
        req_rw[0] = 1'b0; req_len2[0] = 1'b1; req[0] = 1'b1;
        n = 0;
        while (!eng.eng_valid && n < 200) begin @(negedge clk); n++; end
        chk("rstmid.valid_seen", eng.eng_valid, 1);
        reset = 1'b0; req = 2'b00;
        @(negedge clk);
        chk("rstmid.gnt", gnt, 0); chk("rstmid.eng_valid", eng.eng_valid, 0);
        chk("rstmid.eng_op", eng.eng_op, 0); chk("rstmid.done", done, 0);
        chk("rstmid.err", err, 0);
        hang = 0;
        reset = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
